data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, memory size in 32-bit words (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 Parameter TOHOST_ADDR, default 32'h0000_1000, byte address of the tohost word.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  core presents a request.
REQ-007 req_ready  output  1  responder accepts a request this cycle.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  byte-lane enables for stores; bit n controls bits 8n+7..8n.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  core consumes the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  access was misaligned or out of range.
REQ-016 tohost_valid  output  1  one-cycle pulse when tohost is written.
REQ-017 tohost_data  output  32  last value stored to TOHOST_ADDR.
REQ-018 halt  output  1  sticky; set by any tohost write whose bit 0 is 1.

Function
REQ-019 FSM states IDLE, WAIT, RESP; exactly one transaction outstanding.
REQ-020 req_ready shall be 1 only in IDLE; a handshake occurs when req_valid & req_ready.
REQ-021 On a handshake: IDLE->WAIT, latency counter loaded with LATENCY-1, address, write flag, and error flag captured.
REQ-022 With LATENCY=1, the transition shall be IDLE->RESP directly, so rsp_valid rises the cycle after acceptance.
REQ-023 In WAIT the counter decrements each cycle; at zero the state goes to RESP.
REQ-024 In RESP rsp_valid=1 with stable rsp_rdata/rsp_err; RESP->IDLE on rsp_ready, and no new request is accepted in that same cycle.
REQ-025 Error: req_addr[1:0]!=0, or word index >= DEPTH_WORDS and req_addr != TOHOST_ADDR; on error no memory state changes.
REQ-026 Stores commit to the array at the acceptance edge; only enabled lanes change; req_wstrb=0 is a legal no-op store.
REQ-027 Load data is read from the array at the acceptance edge and held until the response is consumed.
REQ-028 A store to TOHOST_ADDR updates tohost_data (byte lanes honoured), pulses tohost_valid one cycle after acceptance, and never writes the array.
REQ-029 Loads from TOHOST_ADDR return tohost_data.
REQ-030 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; the upper bits are checked for range and never wrap.
REQ-031 halt, once set, remains 1 until reset; requests are still serviced after halt.

Reset
REQ-032 Assertion of rst_n=0 shall immediately force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, tohost_valid 0, tohost_data 0, halt 0.
REQ-033 Reset during WAIT or RESP shall abandon the transaction; a store already committed stays committed.
REQ-034 Array contents are not reset; they are preloaded by the bench.
REQ-035 req_ready shall be 1 on the first clock edge after rst_n deasserts.

Structure
REQ-036 A shared package holds the FSM state encoding (2 bits), the default TOHOST_ADDR, and the error-cause constants.
REQ-037 One sub-module, mem_array_1rw: word array with per-lane write enable, one synchronous write port, and one combinational read port.

Verification
REQ-038 LATENCY=2: store 0xDEADBEEF to 0x10 with strb 1111, then load 0x10 -> rsp_valid 2 cycles after each acceptance; load returns 0xDEADBEEF, rsp_err 0.
REQ-039 Store 0x000000AA to 0x10 with strb 0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-040 Load 0x12 (misaligned) and load at byte address 4*DEPTH_WORDS -> rsp_err 1, rsp_rdata 0, array unchanged.
REQ-041 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stay stable and req_ready stays 0; then rsp_ready=1 -> req_ready=1 the next cycle.
REQ-042 Store 0x00000001 to TOHOST_ADDR -> tohost_valid pulses once, tohost_data=1, halt=1 and remains 1; the array word at that index is unchanged.
REQ-043 Assert rst_n low during WAIT of a load -> rsp_valid=0 immediately, no response appears, and req_ready=1 after release.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder: FSM encoding,
// default tohost location, error causes and a byte-lane merge helper.
package data_mem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    localparam logic [ERR_W-1:0] ERR_NONE       = 2'd0;
    localparam logic [ERR_W-1:0] ERR_MISALIGNED = 2'd1;
    localparam logic [ERR_W-1:0] ERR_RANGE      = 2'd2;

    // Replace only the byte lanes selected by strb.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_data,
        input logic [DATA_W-1:0] new_data,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_data;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (strb[i]) res[8*i +: 8] = new_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Word array with per-lane write enables: synchronous write, combinational read
// on a single shared address.
module mem_array_1rw
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder with fixed response latency and a
// tohost mailbox word that drives the sticky halt flag.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH_WORDS = 4096,
    parameter int unsigned       LATENCY     = 2,
    parameter logic [DATA_W-1:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              tohost_valid,
    output logic [DATA_W-1:0] tohost_data,
    output logic              halt
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              tohost_valid_q;
    logic [DATA_W-1:0] tohost_data_q;
    logic              halt_q;

    logic              accept_c;
    logic              is_tohost_c;
    logic [ERR_W-1:0]  err_cause_c;
    logic              err_c;
    logic              mem_we_c;
    logic              tohost_we_c;
    logic [DATA_W-1:0] mem_rdata_c;
    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] tohost_merged_c;

    assign req_ready    = (state_q == ST_IDLE);
    assign accept_c     = req_valid && req_ready;
    assign is_tohost_c  = (req_addr == TOHOST_ADDR);

    // Range check looks at every bit above the word index so addresses never alias.
    always_comb begin
        err_cause_c = ERR_NONE;
        if (req_addr[1:0] != 2'b00) begin
            err_cause_c = ERR_MISALIGNED;
        end else if (((req_addr >> (AW + 2)) != '0) && !is_tohost_c) begin
            err_cause_c = ERR_RANGE;
        end
    end

    assign err_c           = (err_cause_c != ERR_NONE);
    assign mem_we_c        = accept_c && req_write && !err_c && !is_tohost_c;
    assign tohost_we_c     = accept_c && req_write && !err_c && is_tohost_c;
    assign tohost_merged_c = merge_lanes(tohost_data_q, req_wdata, req_wstrb);

    always_comb begin
        load_data_c = '0;
        if (!err_c && !req_write) begin
            load_data_c = is_tohost_c ? tohost_data_q : mem_rdata_c;
        end
    end

    mem_array_1rw #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .wstrb   (req_wstrb),
        .addr    (req_addr[AW+1:2]),
        .wdata   (req_wdata),
        .rdata_c (mem_rdata_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (LATENCY <= 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            tohost_valid_q <= 1'b0;
            tohost_data_q  <= '0;
            halt_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tohost_valid_q <= tohost_we_c;
            if (accept_c) begin
                rdata_q <= load_data_c;
                err_q   <= err_c;
            end
            if (tohost_we_c) begin
                tohost_data_q <= tohost_merged_c;
                halt_q        <= halt_q | tohost_merged_c[0];
            end
        end
    end

    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;
    assign tohost_valid = tohost_valid_q;
    assign tohost_data  = tohost_data_q;
    assign halt         = halt_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a reference model predicts each
// response when the request is driven; responses are popped and compared.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned LAT    = 2;
    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        halt;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_mem[int];
    logic [31:0] m_tohost = '0;
    logic        m_halt = 1'b0;
    int          compared = 0;
    int          mismatched = 0;
    int          tohost_pulses = 0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .TOHOST_ADDR (TOHOST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data),
        .halt         (halt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tohost_valid === 1'b1) tohost_pulses <= tohost_pulses + 1;
    end

    function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // Reference model: predicts the response and updates the model state.
    function automatic exp_t model(input logic wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] strb);
        exp_t e;
        int   idx;
        logic [31:0] old;
        e.rdata = '0;
        e.err   = 1'b0;
        idx = int'(addr >> 2);
        if (addr[1:0] != 2'b00 || (idx >= int'(DEPTH) && addr != TOHOST)) begin
            e.err = 1'b1;
        end else if (addr == TOHOST) begin
            if (wr) begin
                m_tohost = lane_merge(m_tohost, wdata, strb);
                if (m_tohost[0]) m_halt = 1'b1;
            end else begin
                e.rdata = m_tohost;
            end
        end else begin
            old = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            if (wr) m_mem[idx] = lane_merge(old, wdata, strb);
            else    e.rdata = old;
        end
        return e;
    endfunction

    task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int hold);
        exp_t e;
        int   n;
        int   lat;
        sb_q.push_back(model(wr, addr, wdata, strb));
        req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL handshake addr=%h: req_ready=%b required 1", addr, req_ready);
            req_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        compared++;
        if (lat != int'(LAT)) begin
            mismatched++;
            $display("FAIL latency addr=%h: got %0d required %0d", addr, lat, LAT);
        end
        e = sb_q.pop_front();
        compared++;
        if (rsp_rdata !== e.rdata) begin
            mismatched++;
            $display("FAIL rdata addr=%h: got %h required %h", addr, rsp_rdata, e.rdata);
        end
        compared++;
        if (rsp_err !== e.err) begin
            mismatched++;
            $display("FAIL err addr=%h: got %b required %b", addr, rsp_err, e.err);
        end
        if (hold > 0) begin
            rsp_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                compared++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err
                    || req_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL hold_stable cyc%0d: valid=%b rdata=%h err=%b ready=%b required 1/%h/%b/0",
                             i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            compared++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL after_consume: req_ready=%b rsp_valid=%b required 1/0",
                         req_ready, rsp_valid);
            end
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
            tohost_valid !== 1'b0 || tohost_data !== 32'h0 || halt !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_values: valid=%b rdata=%h err=%b tv=%b td=%h halt=%b required all 0",
                     rsp_valid, rsp_rdata, rsp_err, tohost_valid, tohost_data, halt);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 0);
    endtask

    task automatic test_byte_lanes();
        send(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 0);
        send(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 0);
        send(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
        send(1'b1, 32'h20, 32'h5566_7788, 4'b1010, 0);
        send(1'b0, 32'h20, 32'h0, 4'h0, 0);
    endtask

    task automatic test_errors();
        send(1'b0, 32'h12, 32'h0, 4'h0, 0);
        send(1'b0, 4 * DEPTH, 32'h0, 4'h0, 0);
        send(1'b1, 32'h12, 32'h1234_5678, 4'hF, 0);
        send(1'b1, 4 * DEPTH + 32'h10, 32'h1234_5678, 4'hF, 0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 0);
        send(1'b0, 4 * DEPTH - 4, 32'h0, 4'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) send(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
        for (int i = 0; i < 4; i++) send(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'h0, 0);
    endtask

    task automatic test_backpressure();
        send(1'b0, 32'h10, 32'h0, 4'h0, 5);
    endtask

    task automatic test_tohost();
        logic [31:0] arr_before;
        int          p0;
        arr_before = dut.u_mem.mem[TOHOST >> 2];
        p0 = tohost_pulses;
        send(1'b1, TOHOST, 32'h0000_0001, 4'hF, 0);
        repeat (3) @(posedge clk); #1;
        compared++;
        if (tohost_pulses - p0 != 1) begin
            mismatched++;
            $display("FAIL tohost_pulse: got %0d pulses required 1", tohost_pulses - p0);
        end
        compared++;
        if (tohost_data !== m_tohost || halt !== m_halt) begin
            mismatched++;
            $display("FAIL tohost_state: data=%h halt=%b required %h/%b",
                     tohost_data, halt, m_tohost, m_halt);
        end
        send(1'b1, TOHOST, 32'h0000_0100, 4'b0010, 0);
        send(1'b0, TOHOST, 32'h0, 4'h0, 0);
        send(1'b0, 32'h10, 32'h0, 4'h0, 0);
        compared++;
        if (tohost_data !== m_tohost || halt !== 1'b1 || tohost_pulses - p0 != 2) begin
            mismatched++;
            $display("FAIL tohost_sticky: data=%h halt=%b pulses=%0d required %h/1/2",
                     tohost_data, halt, tohost_pulses - p0, m_tohost);
        end
        compared++;
        if (dut.u_mem.mem[TOHOST >> 2] !== arr_before) begin
            mismatched++;
            $display("FAIL tohost_array: got %h required %h",
                     dut.u_mem.mem[TOHOST >> 2], arr_before);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int n;
        req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        compared++;
        if (rsp_valid !== 1'b0 || halt !== 1'b0 || tohost_data !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_in_wait: valid=%b halt=%b td=%h required 0/0/0",
                     rsp_valid, halt, tohost_data);
        end
        m_tohost = '0;
        m_halt   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_abort: got %b required 1", req_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid === 1'b1) seen++;
            @(posedge clk); #1;
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL ghost_response: got %0d valid cycles required 0", seen);
        end
        send(1'b0, 32'h10, 32'h0, 4'h0, 0);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_tohost();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
